fft_buffer_ctrl: RTL and testbench
==================================

Name: fft_buffer_ctrl

Overview:
Sequencer for the ping-pong 256-point data buffer (two 56x256 banks, 8 samples per beat, 32 beats per frame) in the 256-point FFT.
- Drives the buffer's `data_valid`, `bank` and eight read pointers through one input load pass, eight radix-2 butterfly stage passes and one bit-reversed unload pass.
- Flags the cycles on which buffer read data is valid for the butterfly array and the output port.

Parameters:
PASS_GAP, 4, idle cycles (`data_valid` low) inserted after every pass so the butterfly pipeline can flush; legal range 0..15.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high; clears all state
start  in  1  one-cycle request to process a frame; ignored while busy
src_valid  in  1  input beat (8 samples) is present on the buffer inputs during LOAD
src_ready  out  1  controller accepts an input beat (high only in LOAD)
data_valid  out  1  buffer write/read enable
bank  out  1  buffer bank select (0: write bank0/read bank1; 1: write bank1/read bank0)
rd_pt  out  64  eight 8-bit read addresses; lane l at bits [8l+7:8l]
stage  out  4  0..7 during stage passes, 8 during UNLOAD, 0 otherwise
bf_valid  out  1  buffer outputs hold valid butterfly operands (stage passes)
out_valid  out  1  buffer outputs hold final bins (UNLOAD)
out_last  out  1  last unload beat
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; beat counter 0; gap counter 0.
- States: IDLE, LOAD, GAP, STAGE, UNLOAD.
- IDLE: on `start`, go to LOAD and set `busy`=1.
- LOAD:
  - `src_ready`=1, `bank`=0.
  - `data_valid`=`src_valid`; each accepted beat increments the 5-bit beat counter `k`.
  - `src_valid` low stalls the pass; the counter holds and `data_valid`=0.
  - After beat 31, go to GAP.
- GAP:
  - `data_valid`=0; `bank` and `rd_pt` hold their last values.
  - Lasts PASS_GAP cycles. With PASS_GAP=0, go directly to the next pass.
  - Next pass: STAGE s=0 after LOAD, s+1 after stage s<7, UNLOAD after stage 7.
- STAGE s (32 cycles):
  - `data_valid`=1 every cycle; `bank`=(s+1) mod 2.
  - For lane pair j=0..3: butterfly index b=4k+j, span D=2^(7-s).
  - top = ((b>>(7-s))<<(8-s)) | (b & (D-1)); bottom = top+D.
  - `rd_pt` lane 2j = top; lane 2j+1 = bottom.
- UNLOAD (32 cycles):
  - `data_valid`=1, `bank`=1, `stage`=8.
  - `rd_pt` lane l = bit-reverse8(8k+l).
  - Buffer writes during UNLOAD are don't-care.
- Read latency: the buffer has 1-cycle read latency.
  - `bf_valid` = `data_valid` registered, qualified by the previous state being STAGE.
  - `out_valid` = the same, qualified by UNLOAD.
  - `out_last` is high on the `out_valid` cycle of beat 31.
  - `done` pulses on that same cycle; the next cycle returns to IDLE with `busy`=0.
- `data_valid` is asserted exactly 32 times per pass. This keeps the buffer's free-running write pointer (step 8, mod 256) aligned to address 0 at every pass boundary.
- Total cycles from first LOAD beat (continuous `src_valid`): 320 active + 9·PASS_GAP, plus 1 to `done`.
- `start` during `busy` is ignored. `start` in the same cycle as `done` is ignored; the frame restarts only from IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The buffer pointer is expected to be reset by the same signal.
- `rd_pt` is registered, glitch-free, and changes only on active beats.

Test Plan:
- Reset, start, `src_valid` held high → `src_ready`=1 for exactly 32 cycles with `bank`=0, then PASS_GAP (4) cycles of `data_valid`=0.
- Stage 0, beat 0 → `rd_pt` lanes 0..7 = 0,128,1,129,2,130,3,131; `bank`=1; `bf_valid` high one cycle later.
- Stage 3, beat 5 → 36,52,37,53,38,54,39,55. Stage 7, beat 0 → 0..7. Stage 7, beat 31 → 248..255. `bank`=0 in stage 7.
- UNLOAD beat 0 → 0,128,64,192,32,160,96,224. Beat 1 → 16,144,80,208,48,176,112,240. `out_valid`, `out_last` and `done` coincide one cycle after beat 31. Total cycle count = 356 with PASS_GAP=4.
- `src_valid` toggled 1,0,1,0 during LOAD → `data_valid` mirrors it; exactly 32 accepted beats; the load pass lasts 64 cycles.
- Assert `reset` during stage 4 → all outputs 0 immediately. A new start then repeats the full sequence with identical addresses; a `start` pulse while `busy` has no effect.

Source files
------------

// File: rtl/fft_buffer_ctrl_if.sv
// Handshake and buffer-control bundle between the FFT buffer sequencer and its environment.
interface fft_buffer_ctrl_if;
    logic        start;
    logic        src_valid;
    logic        src_ready;
    logic        data_valid;
    logic        bank;
    logic [63:0] rd_pt;
    logic [3:0]  stage;
    logic        bf_valid;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        done;

    // Controller side.
    modport master (
        input  start,
        input  src_valid,
        output src_ready,
        output data_valid,
        output bank,
        output rd_pt,
        output stage,
        output bf_valid,
        output out_valid,
        output out_last,
        output busy,
        output done
    );

    // Environment side.
    modport slave (
        output start,
        output src_valid,
        input  src_ready,
        input  data_valid,
        input  bank,
        input  rd_pt,
        input  stage,
        input  bf_valid,
        input  out_valid,
        input  out_last,
        input  busy,
        input  done
    );
endinterface

// File: rtl/fft_buffer_ctrl.sv
// Sequencer for the ping-pong 256-point FFT buffer: one load pass, eight radix-2 stage passes
// and one bit-reversed unload pass, each of 32 beats, separated by PASS_GAP idle cycles.
module fft_buffer_ctrl #(
    parameter int unsigned PASS_GAP = 4
) (
    input  logic              clk,
    input  logic              reset,
    fft_buffer_ctrl_if.master bus
);
    typedef enum logic [2:0] {StIdle, StLoad, StGap, StStage, StUnload} state_e;

    // Pass index: 0 = load, 1..8 = stage 0..7, 9 = unload.
    localparam logic [3:0] UnloadPass = 4'd9;

    state_e      state_q, state_d, prev_q, next_state;
    logic [3:0]  pass_q, pass_d, next_pass;
    logic [3:0]  gap_q, gap_d;
    logic [4:0]  k_q, k_d;
    logic        bank_q, bank_d;
    logic [63:0] rd_pt_q, rd_pt_d;
    logic        dv_q, last_q;
    logic        data_valid, out_valid_w, done_w, pass_end;

    // Read addresses for beat k of a stage pass (pass 1..8) or the unload pass (pass 9).
    function automatic logic [63:0] addr_for(input logic [3:0] pass, input logic [4:0] k);
        logic [63:0] a;
        logic [2:0]  sh;
        logic [7:0]  b, top, span, idx;
        a = '0;
        if (pass == UnloadPass) begin
            for (int l = 0; l < 8; l++) begin
                idx = {k, 3'(l)};
                for (int i = 0; i < 8; i++) begin
                    a[8*l+i] = idx[7-i];
                end
            end
        end else begin
            // Span exponent 7-s with s = pass-1.
            sh   = 3'(4'd8 - pass);
            span = 8'd1 << sh;
            for (int j = 0; j < 4; j++) begin
                b   = {1'b0, k, 2'(j)};
                top = ((b >> sh) << (4'(sh) + 4'd1)) | (b & (span - 8'd1));
                a[16*j   +: 8] = top;
                a[16*j+8 +: 8] = top + span;
            end
        end
        return a;
    endfunction

    assign next_pass  = pass_q + 4'd1;
    assign next_state = (next_pass == UnloadPass) ? StUnload : StStage;

    // State register and per-pass counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            prev_q  <= StIdle;
            pass_q  <= 4'd0;
            gap_q   <= 4'd0;
            k_q     <= 5'd0;
            bank_q  <= 1'b0;
            rd_pt_q <= '0;
            dv_q    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= state_q;
            pass_q  <= pass_d;
            gap_q   <= gap_d;
            k_q     <= k_d;
            bank_q  <= bank_d;
            rd_pt_q <= rd_pt_d;
            dv_q    <= data_valid;
            last_q  <= (k_q == 5'd31);
        end
    end

    // Next-state, beat/gap counting and pass sequencing.
    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        gap_d    = gap_q;
        k_d      = k_q;
        pass_end = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A start coinciding with done is dropped; the frame restarts only from idle.
                if (bus.start && !done_w) begin
                    state_d = StLoad;
                    pass_d  = 4'd0;
                    k_d     = 5'd0;
                end
            end
            StLoad: begin
                if (bus.src_valid) begin
                    k_d      = k_q + 5'd1;
                    pass_end = (k_q == 5'd31);
                end
            end
            StGap: begin
                if (gap_q == 4'(PASS_GAP - 1)) begin
                    state_d = next_state;
                    pass_d  = next_pass;
                    k_d     = 5'd0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            StStage, StUnload: begin
                k_d      = k_q + 5'd1;
                pass_end = (k_q == 5'd31);
            end
            default: state_d = StIdle;
        endcase

        if (pass_end) begin
            if (state_q == StUnload) begin
                state_d = StIdle;
            end else if (PASS_GAP == 0) begin
                state_d = next_state;
                pass_d  = next_pass;
                k_d     = 5'd0;
            end else begin
                state_d = StGap;
                gap_d   = 4'd0;
            end
        end
    end

    // Bank and read pointers are set up one cycle ahead so they are registered on each beat.
    always_comb begin
        bank_d  = bank_q;
        rd_pt_d = rd_pt_q;
        unique case (state_d)
            StIdle, StLoad: bank_d = 1'b0;
            StStage: begin
                bank_d  = pass_d[0];
                rd_pt_d = addr_for(pass_d, k_d);
            end
            StUnload: begin
                bank_d  = 1'b1;
                rd_pt_d = addr_for(pass_d, k_d);
            end
            default: ;
        endcase
    end

    assign data_valid = (state_q == StLoad && bus.src_valid) || (state_q == StStage) ||
                        (state_q == StUnload);

    // Buffer read data lags the address by one cycle, hence the registered qualifiers.
    assign out_valid_w = dv_q && (prev_q == StUnload);
    assign done_w      = out_valid_w && last_q;

    assign bus.src_ready  = (state_q == StLoad);
    assign bus.data_valid = data_valid;
    assign bus.bank       = bank_q;
    assign bus.rd_pt      = rd_pt_q;
    assign bus.stage      = (state_q == StStage)  ? pass_q - 4'd1 :
                            (state_q == StUnload) ? 4'd8 : 4'd0;
    assign bus.bf_valid   = dv_q && (prev_q == StStage);
    assign bus.out_valid  = out_valid_w;
    assign bus.out_last   = done_w;
    assign bus.done       = done_w;
    assign bus.busy       = (state_q != StIdle) || done_w;
endmodule

// File: tb/tb_fft_buffer_ctrl.sv
// Self-checking bench for fft_buffer_ctrl: expected read beats are queued per frame and popped
// as the controller issues them.
module tb_fft_buffer_ctrl;
    logic clk = 1'b0;
    logic reset;

    fft_buffer_ctrl_if bus_if ();

    fft_buffer_ctrl #(.PASS_GAP(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  stg;
        logic [4:0]  k;
        logic        bnk;
        logic [63:0] rd;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic exp_bf, exp_ov, exp_done;
    logic s_ready, s_dv, s_done, s_busy;
    logic [3:0] s_stage;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] lanes(input int v0, input int v1, input int v2, input int v3,
                                          input int v4, input int v5, input int v6, input int v7);
        return {8'(v7), 8'(v6), 8'(v5), 8'(v4), 8'(v3), 8'(v2), 8'(v1), 8'(v0)};
    endfunction

    // Butterfly top address: butterfly index with a zero bit inserted at position p.
    function automatic logic [7:0] ins_zero(input int b, input int p);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (i < p)       r[i] = b[i];
            else if (i == p) r[i] = 1'b0;
            else             r[i] = b[i-1];
        end
        return r;
    endfunction

    function automatic logic [7:0] rev8(input int v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic push_frame();
        exp_t       e;
        logic [7:0] t;
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 32; k++) begin
                e.stg = 4'(s);
                e.k   = 5'(k);
                e.bnk = 1'((s + 1) % 2);
                e.rd  = '0;
                for (int j = 0; j < 4; j++) begin
                    t = ins_zero(k * 4 + j, 7 - s);
                    e.rd[16*j   +: 8] = t;
                    e.rd[16*j+8 +: 8] = t | (8'd1 << (7 - s));
                end
                sb.push_back(e);
            end
        end
        for (int k = 0; k < 32; k++) begin
            e.stg = 4'd8;
            e.k   = 5'(k);
            e.bnk = 1'b1;
            for (int l = 0; l < 8; l++) e.rd[8*l +: 8] = rev8(k * 8 + l);
            sb.push_back(e);
        end
    endtask

    task automatic monitor();
        exp_t        e;
        logic [63:0] spot;
        bit          has;
        s_ready = bus_if.src_ready;
        s_dv    = bus_if.data_valid;
        s_done  = bus_if.done;
        s_busy  = bus_if.busy;
        s_stage = bus_if.stage;
        chk("bf_valid", bus_if.bf_valid, exp_bf);
        chk("out_valid", bus_if.out_valid, exp_ov);
        chk("out_last", bus_if.out_last, exp_done);
        chk("done", bus_if.done, exp_done);
        exp_bf   = 1'b0;
        exp_ov   = 1'b0;
        exp_done = 1'b0;
        if (s_ready) begin
            chk("load_dv", bus_if.data_valid, bus_if.src_valid);
            chk("load_bank", bus_if.bank, 64'd0);
        end else if (s_dv) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(s_dv), 64'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("rd_pt_s%0d_k%0d", e.stg, e.k), bus_if.rd_pt, e.rd);
                chk($sformatf("bank_s%0d_k%0d", e.stg, e.k), bus_if.bank, e.bnk);
                chk($sformatf("stage_s%0d_k%0d", e.stg, e.k), bus_if.stage, e.stg);
                has  = 1'b1;
                spot = '0;
                case ({e.stg, e.k})
                    {4'd0, 5'd0}:  spot = lanes(0, 128, 1, 129, 2, 130, 3, 131);
                    {4'd3, 5'd5}:  spot = lanes(36, 52, 37, 53, 38, 54, 39, 55);
                    {4'd7, 5'd0}:  spot = lanes(0, 1, 2, 3, 4, 5, 6, 7);
                    {4'd7, 5'd31}: spot = lanes(248, 249, 250, 251, 252, 253, 254, 255);
                    {4'd8, 5'd0}:  spot = lanes(0, 128, 64, 192, 32, 160, 96, 224);
                    {4'd8, 5'd1}:  spot = lanes(16, 144, 80, 208, 48, 176, 112, 240);
                    default:       has = 1'b0;
                endcase
                if (has) chk($sformatf("spot_s%0d_k%0d", e.stg, e.k), bus_if.rd_pt, spot);
                if (e.stg == 4'd7) chk("s7_bank", bus_if.bank, 64'd0);
                exp_bf   = (e.stg != 4'd8);
                exp_ov   = (e.stg == 4'd8);
                exp_done = (e.stg == 4'd8) && (e.k == 5'd31);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (!reset) monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"}, bus_if.busy, 64'd0);
        chk({pfx, "_ready"}, bus_if.src_ready, 64'd0);
        chk({pfx, "_dv"}, bus_if.data_valid, 64'd0);
        chk({pfx, "_bank"}, bus_if.bank, 64'd0);
        chk({pfx, "_rd_pt"}, bus_if.rd_pt, 64'd0);
        chk({pfx, "_stage"}, bus_if.stage, 64'd0);
        chk({pfx, "_bf"}, bus_if.bf_valid, 64'd0);
        chk({pfx, "_ov"}, bus_if.out_valid, 64'd0);
        chk({pfx, "_last"}, bus_if.out_last, 64'd0);
        chk({pfx, "_done"}, bus_if.done, 64'd0);
    endtask

    task automatic run_frame(input bit toggle, input bit reset_mid, input int exp_total);
        int ready_cnt, acc, last_ready, first_stage, done_at, ready_first;
        push_frame();
        bus_if.start     = 1'b1;
        bus_if.src_valid = 1'b1;
        step();
        bus_if.start = 1'b0;
        ready_cnt   = 0;
        acc         = 0;
        last_ready  = -1;
        first_stage = -1;
        done_at     = -1;
        ready_first = -1;
        for (int c = 0; c < 1000 && done_at < 0; c++) begin
            bus_if.src_valid = toggle ? 1'(c % 2) : 1'b1;
            // Start while busy (c == 100) and on the done cycle must both be ignored.
            bus_if.start = (c == 100) || (c == exp_total);
            step();
            if (s_ready) begin
                ready_cnt++;
                last_ready = c;
                if (ready_first < 0) ready_first = c;
                if (s_dv) acc++;
            end else if (s_dv && first_stage < 0) begin
                first_stage = c;
            end
            if (s_done) done_at = c;
            if (reset_mid && s_busy && s_stage == 4'd4) break;
        end
        bus_if.start = 1'b0;
        chk("ready_first", 64'(ready_first), 64'd0);
        chk("load_len", 64'(ready_cnt), toggle ? 64'd64 : 64'd32);
        chk("load_beats", 64'(acc), 64'd32);
        chk("gap_len", 64'(first_stage - last_ready - 1), 64'd4);
        if (reset_mid) begin
            reset = 1'b1;
            #2;
            chk_zero("midrst");
            sb.delete();
            exp_bf   = 1'b0;
            exp_ov   = 1'b0;
            exp_done = 1'b0;
            @(negedge clk);
            reset            = 1'b0;
            bus_if.src_valid = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            chk("total_cycles", 64'(done_at), 64'(exp_total));
            step();
            chk("after_done_busy", s_busy, 64'd0);
            chk("after_done_ready", s_ready, 64'd0);
            chk("sb_drained", 64'(sb.size()), 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        reset            = 1'b1;
        bus_if.start     = 1'b0;
        bus_if.src_valid = 1'b0;
        exp_bf           = 1'b0;
        exp_ov           = 1'b0;
        exp_done         = 1'b0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();
        chk("idle_busy", s_busy, 64'd0);
        chk("idle_ready", s_ready, 64'd0);

        run_frame(1'b0, 1'b0, 356);
        run_frame(1'b1, 1'b0, 388);
        run_frame(1'b0, 1'b1, 356);
        run_frame(1'b0, 1'b0, 356);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
